// File: rtl/vedic_mac_pkg.sv
// Shared definitions for the vedic MAC stage.
// Contents: multiplier latency, terms-counter width, accumulator state
// encoding, per-result metadata struct and the saturating term-count increment.
package vedic_mac_pkg;

    localparam int MUL_LAT = 3;
    localparam int TERMS_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } mac_state_e;

    // Result metadata; the accumulator width is a module parameter, so the
    // top pairs this with a sum field of its own width to form a FIFO entry.
    typedef struct packed {
        logic [TERMS_W-1:0] terms;
        logic               ovf;
    } mac_meta_t;

    function automatic logic [TERMS_W-1:0] terms_sat_inc(input logic [TERMS_W-1:0] t);
        logic [TERMS_W-1:0] r;
        if (t == {TERMS_W{1'b1}}) begin
            r = t;
        end else begin
            r = t + TERMS_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/vedic_mac_16bit_if.sv
// Beat input / result output bundle of the vedic MAC stage.
// master: producer/consumer side (drives beats and out_ready).
// slave : the MAC (drives in_ready, results and err_orphan).
interface vedic_mac_16bit_if #(parameter int ACC_W = 40);
    import vedic_mac_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic               in_first;
    logic               in_last;
    logic [15:0]        in_a;
    logic [15:0]        in_b;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_sum;
    logic [TERMS_W-1:0] out_terms;
    logic               out_ovf;
    logic               err_orphan;

    modport master (
        output in_valid, in_first, in_last, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_terms, out_ovf, err_orphan
    );

    modport slave (
        input  in_valid, in_first, in_last, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_terms, out_ovf, err_orphan
    );
endinterface

// File: rtl/mac_result_fifo.sv
// Synchronous FIFO with occupancy count. Pop on empty is ignored; pushing
// while full is prevented by the caller's credit scheme.
// Ports: clk, rst_n (async active-low); push/din; pop; dout (head); count.
module mac_result_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count
);
    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(DEPTH - 1)) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Qualify pop with non-empty.
    always_comb begin
        do_pop_s = pop && (count_r != {CNT_W{1'b0}});
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
endmodule

// File: rtl/simple_vedic_16bit.sv
// 3-stage pipelined 16x16 unsigned multiplier built from four 8x8 vedic
// partial products. Datapath only, no reset.
// Ports: clk; a, b (16-bit operands); s (32-bit product, 3 edges after a/b).
module simple_vedic_16bit (
    input  logic        clk,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] s
);
    logic [15:0] pp_ll_r, pp_lh_r, pp_hl_r, pp_hh_r;
    logic [15:0] lo_r, hi_r;
    logic [16:0] mid_r;

    // Stage 1: four 8x8 partial products.
    always_ff @(posedge clk) begin
        pp_ll_r <= {8'd0, a[7:0]}  * {8'd0, b[7:0]};
        pp_lh_r <= {8'd0, a[7:0]}  * {8'd0, b[15:8]};
        pp_hl_r <= {8'd0, a[15:8]} * {8'd0, b[7:0]};
        pp_hh_r <= {8'd0, a[15:8]} * {8'd0, b[15:8]};
    end

    // Stage 2: fold the two cross terms.
    always_ff @(posedge clk) begin
        mid_r <= {1'b0, pp_lh_r} + {1'b0, pp_hl_r};
        lo_r  <= pp_ll_r;
        hi_r  <= pp_hh_r;
    end

    // Stage 3: combine outer terms with the cross sum shifted by 8.
    always_ff @(posedge clk) begin
        s <= {hi_r, lo_r} + {7'd0, mid_r, 8'd0};
    end
endmodule

// File: rtl/vedic_mac_16bit.sv
// Streaming dot-product stage: multiplies accepted digit pairs, accumulates
// products between first/last markers and queues each completed sum.
// Ports: clk, rst_n (async active-low); bus (slave): beat input with
// in_valid/in_ready/in_first/in_last/in_a/in_b, result output with
// out_valid/out_ready/out_sum/out_terms/out_ovf, and err_orphan pulse.
module vedic_mac_16bit
    import vedic_mac_pkg::*;
#(
    parameter int ACC_W     = 40,
    parameter int OUT_DEPTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    vedic_mac_16bit_if.slave  bus
);
    localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
    localparam int LIF_W  = $clog2(MUL_LAT + 2);
    localparam int CRED_W = $clog2(OUT_DEPTH + MUL_LAT + 2);

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        mac_meta_t        meta;
    } entry_t;

    // Index 0 is the operand register; index MUL_LAT lines up with prod_s.
    logic [MUL_LAT:0]   v_r, f_r, l_r;
    logic [15:0]        a_r, b_r;
    logic [31:0]        prod_s;
    mac_state_e         state_r;
    logic [ACC_W-1:0]   acc_r;
    logic [TERMS_W-1:0] terms_r;
    logic               ovf_r;
    logic               err_orphan_r;
    logic [LIF_W-1:0]   lif_r;
    logic [CNT_W-1:0]   fifo_count_s;
    entry_t             head_s, entry_s;

    logic               accept_s, push_s, restart_s, orphan_s;
    logic [ACC_W:0]     add_s;
    logic [ACC_W-1:0]   sum_n_s;
    logic [TERMS_W-1:0] terms_n_s;
    logic               ovf_n_s;
    logic [CRED_W-1:0]  credit_s;

    // Operand register feeding the multiplier; flags gate its use.
    always_ff @(posedge clk) begin
        a_r <= bus.in_a;
        b_r <= bus.in_b;
    end

    simple_vedic_16bit u_mul (
        .clk (clk),
        .a   (a_r),
        .b   (b_r),
        .s   (prod_s)
    );

    // Flag pipeline running alongside the multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r <= {(MUL_LAT+1){1'b0}};
            f_r <= {(MUL_LAT+1){1'b0}};
            l_r <= {(MUL_LAT+1){1'b0}};
        end else begin
            v_r <= {v_r[MUL_LAT-1:0], accept_s};
            f_r <= {f_r[MUL_LAT-1:0], bus.in_first};
            l_r <= {l_r[MUL_LAT-1:0], bus.in_last};
        end
    end

    // Next accumulator values for the beat whose product is on prod_s.
    always_comb begin
        accept_s  = bus.in_valid && bus.in_ready;
        push_s    = v_r[MUL_LAT] && l_r[MUL_LAT];
        // A non-first beat with no open sum starts one anyway.
        restart_s = f_r[MUL_LAT] || (state_r == IDLE);
        if (v_r[MUL_LAT]) begin
            orphan_s = f_r[MUL_LAT] ? (state_r == ACCUM) : (state_r == IDLE);
        end else begin
            orphan_s = 1'b0;
        end
        add_s = {1'b0, acc_r} + {1'b0, ACC_W'(prod_s)};
        if (restart_s) begin
            sum_n_s   = ACC_W'(prod_s);
            terms_n_s = TERMS_W'(1);
            ovf_n_s   = 1'b0;
        end else begin
            sum_n_s   = add_s[ACC_W-1:0];
            terms_n_s = terms_sat_inc(terms_r);
            ovf_n_s   = ovf_r | add_s[ACC_W];
        end
        entry_s.sum        = sum_n_s;
        entry_s.meta.terms = terms_n_s;
        entry_s.meta.ovf   = ovf_n_s;
    end

    // Accumulator state machine and orphan pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            acc_r        <= {ACC_W{1'b0}};
            terms_r      <= {TERMS_W{1'b0}};
            ovf_r        <= 1'b0;
            err_orphan_r <= 1'b0;
        end else begin
            err_orphan_r <= orphan_s;
            if (v_r[MUL_LAT]) begin
                if (l_r[MUL_LAT]) begin
                    state_r <= IDLE;
                    acc_r   <= {ACC_W{1'b0}};
                    terms_r <= {TERMS_W{1'b0}};
                    ovf_r   <= 1'b0;
                end else begin
                    state_r <= ACCUM;
                    acc_r   <= sum_n_s;
                    terms_r <= terms_n_s;
                    ovf_r   <= ovf_n_s;
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Last beats accepted but not yet written to the FIFO: each holds a
    // reserved FIFO slot because the multiplier pipeline cannot stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lif_r <= {LIF_W{1'b0}};
        end else begin
            case ({accept_s && bus.in_last, push_s})
                2'b10:   lif_r <= lif_r + LIF_W'(1);
                2'b01:   lif_r <= lif_r - LIF_W'(1);
                default: lif_r <= lif_r;
            endcase
        end
    end

    mac_result_fifo #(.W($bits(entry_t)), .DEPTH(OUT_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (entry_s),
        .pop   (bus.out_ready),
        .dout  (head_s),
        .count (fifo_count_s)
    );

    assign credit_s       = CRED_W'(fifo_count_s) + CRED_W'(lif_r);
    assign bus.in_ready   = credit_s < CRED_W'(OUT_DEPTH);
    assign bus.out_valid  = fifo_count_s != {CNT_W{1'b0}};
    assign bus.out_sum    = head_s.sum;
    assign bus.out_terms  = head_s.meta.terms;
    assign bus.out_ovf    = head_s.meta.ovf;
    assign bus.err_orphan = err_orphan_r;
endmodule

// File: tb/tb_vedic_mac_16bit.sv
`timescale 1ns/1ps
module tb_vedic_mac_16bit;
    import vedic_mac_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vedic_mac_16bit_if #(.ACC_W(40)) bus   ();
    vedic_mac_16bit_if #(.ACC_W(33)) bus33 ();

    vedic_mac_16bit #(.ACC_W(40), .OUT_DEPTH(4)) u_dut (
        .clk (clk), .rst_n (rst_n), .bus (bus.slave)
    );
    vedic_mac_16bit #(.ACC_W(33), .OUT_DEPTH(4)) u_dut33 (
        .clk (clk), .rst_n (rst_n), .bus (bus33.slave)
    );

    typedef logic [48:0] res_t;   // {sum[39:0], terms[7:0], ovf}
    typedef logic [41:0] res33_t; // {sum[32:0], terms[7:0], ovf}

    res_t   obs_q[$];
    res33_t obs33_q[$];
    int     err_seen = 0;
    int     obs_rd   = 0;
    int     n_vec    = 0;
    int     n_bad    = 0;

    // Result / error monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready)
                obs_q.push_back({bus.out_sum, bus.out_terms, bus.out_ovf});
            if (bus33.out_valid && bus33.out_ready)
                obs33_q.push_back({bus33.out_sum, bus33.out_terms, bus33.out_ovf});
            if (bus.err_orphan)
                err_seen++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic beat(input logic f, input logic l, input logic [15:0] a, input logic [15:0] b);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!bus.in_ready && w < 100) begin
            tick();
            w++;
        end
        if (!bus.in_ready) chk("beat_ready", {63'd0, bus.in_ready}, 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [39:0] sum,
                              input logic [7:0] terms, input logic ovf);
        if (obs_rd < obs_q.size()) begin
            chk(tag, {15'd0, obs_q[obs_rd]}, {15'd0, sum, terms, ovf});
            obs_rd++;
        end else begin
            chk({tag, "_count"}, 64'(obs_q.size()), 64'(obs_rd + 1));
        end
    endtask

    // Transaction-level soak model state.
    logic        m_accum;
    logic [39:0] m_acc;
    logic [7:0]  m_terms;
    logic        m_ovf;
    int          m_err;
    res_t        exp_q[$];

    task automatic model_beat(input logic f, input logic l, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] prod;
        logic [40:0] wide;
        prod = {16'd0, a} * {16'd0, b};
        if (f && m_accum)   m_err++;
        if (!f && !m_accum) m_err++;
        if (f || !m_accum) begin
            m_acc = {8'd0, prod}; m_terms = 8'd1; m_ovf = 1'b0;
        end else begin
            wide    = {1'b0, m_acc} + {9'd0, prod};
            m_acc   = wide[39:0];
            m_ovf   = m_ovf | wide[40];
            m_terms = (m_terms == 8'd255) ? 8'd255 : m_terms + 8'd1;
        end
        if (l) begin
            exp_q.push_back({m_acc, m_terms, m_ovf});
            m_accum = 1'b0;
            m_acc   = 40'd0;
        end else begin
            m_accum = 1'b1;
        end
    endtask

    initial begin
        int err_base, acc_n, n_acc, cyc, obs_base, n_cmp;

        bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
        bus.in_a = 16'd0; bus.in_b = 16'd0; bus.out_ready = 1'b1;
        bus33.in_valid = 1'b0; bus33.in_first = 1'b0; bus33.in_last = 1'b0;
        bus33.in_a = 16'd0; bus33.in_b = 16'd0; bus33.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {63'd0, bus.in_ready},   64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid},  64'd0);
        chk("rst_out_sum",   {24'd0, bus.out_sum},    64'd0);
        chk("rst_out_terms", {56'd0, bus.out_terms},  64'd0);
        chk("rst_out_ovf",   {63'd0, bus.out_ovf},    64'd0);
        chk("rst_err",       {63'd0, bus.err_orphan}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Single term, 4-cycle latency
        bus.in_valid = 1'b1; bus.in_first = 1'b1; bus.in_last = 1'b1;
        bus.in_a = 16'hFFFF; bus.in_b = 16'hFFFF;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) begin
                chk("single_early", {63'd0, bus.out_valid}, 64'd0);
            end else begin
                chk("single_valid", {63'd0, bus.out_valid}, 64'd1);
                chk("single_sum",   {24'd0, bus.out_sum},   64'hFFFE0001);
                chk("single_terms", {56'd0, bus.out_terms}, 64'd1);
                chk("single_ovf",   {63'd0, bus.out_ovf},   64'd0);
            end
        end
        idle(2);
        expect_res("single_q", 40'hFFFE0001, 8'd1, 1'b0);

        // Dot product, back-to-back beats
        err_base = err_seen;
        beat(1'b1, 1'b0, 16'd3, 16'd5);
        beat(1'b0, 1'b0, 16'd7, 16'd11);
        beat(1'b0, 1'b0, 16'h1234, 16'h0010);
        beat(1'b0, 1'b1, 16'hFFFF, 16'h0001);
        idle(6);
        expect_res("dot_sum", 40'd15 + 40'd77 + 40'h12340 + 40'hFFFF, 8'd4, 1'b0);
        chk("dot_err", 64'(err_seen - err_base), 64'd0);

        // Term counter saturates at 255
        beat(1'b1, 1'b0, 16'd1, 16'd1);
        for (int i = 0; i < 298; i++) beat(1'b0, 1'b0, 16'd1, 16'd1);
        beat(1'b0, 1'b1, 16'd1, 16'd1);
        idle(6);
        expect_res("sat_terms", 40'd300, 8'd255, 1'b0);

        // Overflow on the 33-bit instance
        for (int i = 0; i < 3; i++) begin
            bus33.in_valid = 1'b1;
            bus33.in_first = (i == 0);
            bus33.in_last  = (i == 2);
            bus33.in_a = 16'hFFFF; bus33.in_b = 16'hFFFF;
            tick();
        end
        bus33.in_valid = 1'b0;
        idle(6);
        chk("ovf_count", 64'(obs33_q.size()), 64'd1);
        if (obs33_q.size() >= 1)
            chk("ovf_result", {22'd0, obs33_q[0]}, {22'd0, 33'h0FFFA0003, 8'd3, 1'b1});

        // Backpressure: credit closes after exactly OUT_DEPTH lasts
        bus.out_ready = 1'b0;
        acc_n = 0;
        bus.in_valid = 1'b1; bus.in_first = 1'b1; bus.in_last = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.in_a = 16'(acc_n + 1);
            bus.in_b = 16'(acc_n + 3);
            if (bus.in_ready) acc_n++;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("bp_accepted",  64'(acc_n), 64'd4);
        chk("bp_in_ready",  {63'd0, bus.in_ready},  64'd0);
        chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("bp_no_pop",    64'(obs_q.size()), 64'(obs_rd));
        bus.out_ready = 1'b1;
        idle(8);
        for (int i = 0; i < 4; i++) expect_res("bp_order", 40'((i + 1) * (i + 3)), 8'd1, 1'b0);
        chk("bp_no_dup",      64'(obs_q.size()), 64'(obs_rd));
        chk("bp_ready_again", {63'd0, bus.in_ready}, 64'd1);

        // Protocol errors: first inside a sum, then an orphan non-first
        err_base = err_seen;
        beat(1'b1, 1'b0, 16'd2, 16'd3);
        beat(1'b1, 1'b1, 16'd4, 16'd5);
        beat(1'b0, 1'b1, 16'd6, 16'd7);
        idle(6);
        expect_res("proto_restart", 40'd20, 8'd1, 1'b0);
        expect_res("proto_orphan",  40'd42, 8'd1, 1'b0);
        chk("proto_err", 64'(err_seen - err_base), 64'd2);

        // Reset with one FIFO entry and two beats in flight
        bus.out_ready = 1'b0;
        beat(1'b1, 1'b1, 16'd9, 16'd9);
        idle(6);
        beat(1'b1, 1'b0, 16'd1, 16'd1);
        beat(1'b0, 1'b0, 16'd1, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("mid_rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        chk("mid_rst_out_sum",   {24'd0, bus.out_sum},   64'd0);
        chk("mid_rst_terms",     {56'd0, bus.out_terms}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        beat(1'b1, 1'b1, 16'd2, 16'd3);
        idle(6);
        expect_res("rst_fresh", 40'd6, 8'd1, 1'b0);
        chk("rst_no_stale", 64'(obs_q.size()), 64'(obs_rd));

        // Random soak against the transaction model
        m_accum = 1'b0; m_acc = 40'd0; m_terms = 8'd0; m_ovf = 1'b0; m_err = 0;
        err_base = err_seen;
        obs_base = obs_q.size();
        n_acc = 0;
        cyc = 0;
        while (n_acc < 10000 && cyc < 60000) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_first  = ($urandom_range(0, 4) == 0);
            bus.in_last   = ($urandom_range(0, 4) == 0);
            bus.in_a      = 16'($urandom);
            bus.in_b      = 16'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (bus.in_valid && bus.in_ready) begin
                model_beat(bus.in_first, bus.in_last, bus.in_a, bus.in_b);
                n_acc++;
            end
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle(20);
        chk("soak_beats", 64'(n_acc), 64'd10000);
        chk("soak_count", 64'(obs_q.size() - obs_base), 64'(exp_q.size()));
        n_cmp = exp_q.size();
        if (obs_q.size() - obs_base < n_cmp) n_cmp = obs_q.size() - obs_base;
        for (int i = 0; i < n_cmp; i++)
            chk("soak_result", {15'd0, obs_q[obs_base + i]}, {15'd0, exp_q[i]});
        chk("soak_err", 64'(err_seen - err_base), 64'(m_err));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
